// File: rtl/cic_pkg.sv
// Shared definitions for the audio CIC decimator.
// Default geometry is 16-bit audio, order 3, decimation by 30 (960 kHz -> 32 kHz).
// acc_width() returns the register growth needed to hold a gain of R^N without
// loss: IN_W + ceil(log2(R^N)).
package cic_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 16;
    localparam int R     = 30;
    localparam int N     = 3;

    function automatic int acc_width(input int in_w, input int n, input int r);
        return in_w + $clog2(r ** n);
    endfunction

    localparam int ACC_W = acc_width(IN_W, N, R);

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE,
        COMB,
        OUT
    } state_t;

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: a free-running modular accumulator.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   en            accumulate strobe (one clk per input sample)
//   add           value added on each strobe
//   acc           accumulator value; wraps at W bits by design
module cic_integrator #(
    parameter int W = 31
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] add,
    output logic [W-1:0] acc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + add;
        end
    end

endmodule

// File: rtl/audio_cic_decimator.sv
// CIC decimator feeding the codec controller: N integrators run on every en960k
// sample, every R-th sample the last integrator is snapshotted, and a small FSM
// runs the N comb stages one per clk before publishing a new audio word.
//
// state | meaning
// IDLE  | waiting for a decimation event (go)
// COMB  | evaluating comb stage c, one stage per clk
// OUT   | audio_dat holds the new word, dout_valid high for this clk
//
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   en960k        input sample strobe, one clk wide
//   din           two's-complement input sample, valid with en960k
//   audio_dat     decimated output word, held between updates
//   dout_valid    one-clk pulse while a fresh audio_dat is presented
//   overrun       sticky: a decimation event arrived while the combs were busy
module audio_cic_decimator #(
    parameter int IN_W  = cic_pkg::IN_W,
    parameter int OUT_W = cic_pkg::OUT_W,
    parameter int R     = cic_pkg::R,
    parameter int N     = cic_pkg::N
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en960k,
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] audio_dat,
    output logic             dout_valid,
    output logic             overrun
);

    import cic_pkg::*;

    localparam int ACC_W  = acc_width(IN_W, N, R);
    localparam int DCNT_W = $clog2(R);
    localparam int CW     = (N > 1) ? $clog2(N) : 1;

    logic [ACC_W-1:0]  din_ext;
    logic [ACC_W-1:0]  add   [N];
    logic [ACC_W-1:0]  integ [N];
    logic [ACC_W-1:0]  last_next;
    logic [ACC_W-1:0]  snap;
    logic [DCNT_W-1:0] dcnt;
    logic              go;

    state_t            state, state_next;
    logic [CW-1:0]     c;
    logic [ACC_W-1:0]  x;
    logic [ACC_W-1:0]  dly [N];
    logic [ACC_W-1:0]  comb_y;

    assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

    // Stage k adds the pre-update value of stage k-1, so the chain is pipelined.
    for (genvar k = 0; k < N; k++) begin : g_int
        if (k == 0) begin : g_first
            assign add[k] = din_ext;
        end else begin : g_rest
            assign add[k] = integ[k-1];
        end
        cic_integrator #(.W(ACC_W)) u_int (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en960k),
            .add     (add[k]),
            .acc     (integ[k])
        );
    end

    // Value the last integrator takes on this strobe, so snap sees the
    // sample that closes the decimation window.
    assign last_next = integ[N-1] + add[N-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt <= '0;
            snap <= '0;
            go   <= 1'b0;
        end else begin
            go <= 1'b0;
            if (en960k) begin
                if (dcnt == DCNT_W'(R-1)) begin
                    dcnt <= '0;
                    snap <= last_next;
                    go   <= 1'b1;
                end else begin
                    dcnt <= dcnt + DCNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dout_valid = 1'b0;
        case (state)
            IDLE: if (go) state_next = COMB;
            COMB: if (c == CW'(N-1)) state_next = OUT;
            OUT: begin
                dout_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign comb_y = x - dly[c];

    // audio_dat is loaded on the clk that finishes the last comb, so it is
    // already stable during the OUT clk that carries dout_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c         <= '0;
            x         <= '0;
            audio_dat <= '0;
            overrun   <= 1'b0;
            for (int k = 0; k < N; k++) dly[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        x <= snap;
                        c <= '0;
                    end
                end
                COMB: begin
                    dly[c] <= x;
                    x      <= comb_y;
                    if (c == CW'(N-1)) begin
                        audio_dat <= comb_y[ACC_W-1 -: OUT_W];
                    end else begin
                        c <= c + CW'(1);
                    end
                end
                default: ;
            endcase
            if (go && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_cic_decimator.sv
module tb_audio_cic_decimator;

    localparam int TR   = 30;
    localparam int TN   = 3;
    localparam int TACC = 31;
    localparam int TSH  = 15;
    localparam int HLEN = TN * (TR - 1) + 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en960k = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] audio_dat, d3_dat;
    logic        dout_valid, overrun, d3_valid, d3_ovr;

    always #2 clk = ~clk;

    audio_cic_decimator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en960k     (en960k),
        .din        (din),
        .audio_dat  (audio_dat),
        .dout_valid (dout_valid),
        .overrun    (overrun)
    );

    audio_cic_decimator #(.R(3)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .en960k     (en960k),
        .din        (din),
        .audio_dat  (d3_dat),
        .dout_valid (d3_valid),
        .overrun    (d3_ovr)
    );

    typedef struct {
        longint v;
        longint due;
    } exp_t;

    longint h [HLEN];
    int     hist [$];
    exp_t   exp_q [$];
    longint out_log [$];
    longint cyc = 0;
    int     rd_idx = 0;
    int     total = 0;
    int     bad = 0;
    int     d3_cnt = 0;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Impulse response of N cascaded length-R boxcars.
    function automatic void build_h();
        longint cur [HLEN];
        longint nxt [HLEN];
        for (int j = 0; j < HLEN; j++) cur[j] = (j < TR) ? 1 : 0;
        for (int s = 1; s < TN; s++) begin
            for (int j = 0; j < HLEN; j++) begin
                nxt[j] = 0;
                for (int i = 0; i < TR; i++)
                    if (j - i >= 0) nxt[j] += cur[j - i];
            end
            cur = nxt;
        end
        h = cur;
    endfunction

    // Output for the window closed by sample n: FIR over the history (the
    // integrator pipeline delays the input by N-1 samples), wrapped to the
    // accumulator width, then floor-scaled to 16 bits.
    function automatic longint model_out(input int n);
        longint s = 0;
        longint m = (longint'(1) <<< TACC);
        for (int j = 0; j < HLEN; j++) begin
            int idx = n - (TN - 1) - j;
            if (idx >= 0) s += h[j] * longint'(hist[idx]);
        end
        s = s & (m - 1);
        if (s >= (m >>> 1)) s -= m;
        return s >>> TSH;
    endfunction

    function automatic longint logv(input int i);
        if (i < out_log.size()) return out_log[i];
        return -1000000;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (en960k) begin
                hist.push_back(int'($signed(din)));
                if (hist.size() % TR == 0) begin
                    exp_t e;
                    e.v   = model_out(hist.size() - 1);
                    e.due = cyc + 5;
                    exp_q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            rd_idx = 0;
        end else if (dout_valid) begin
            out_log.push_back(longint'($signed(audio_dat)));
            if (rd_idx >= exp_q.size()) begin
                chk("dout_unexpected", 1, 0);
            end else begin
                chk("audio_dat", longint'($signed(audio_dat)), exp_q[rd_idx].v);
                chk("dout_latency", cyc, exp_q[rd_idx].due);
                rd_idx++;
            end
        end else if (rd_idx < exp_q.size() && cyc > exp_q[rd_idx].due) begin
            chk("dout_missing", 0, 1);
            rd_idx++;
        end
    end

    always @(negedge clk) if (d3_valid) d3_cnt++;

    task automatic send(input int v, input int gap);
        en960k = 1'b1;
        din    = 16'(v);
        @(negedge clk);
        en960k = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int base;
    int d3_base;

    initial begin
        build_h();
        repeat (3) @(negedge clk);
        chk("rst_audio_dat", audio_dat, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_r3_overrun", d3_ovr, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // DC +1000, one sample every 250 clks
        base = out_log.size();
        for (int i = 0; i < 150; i++) send(1000, 250);
        repeat (10) @(negedge clk);
        chk("dcp_count", out_log.size() - base, 5);
        chk("dcp_out3", logv(base + 3), 823);
        chk("dcp_out4", logv(base + 4), 823);

        // reset while the combs are running
        for (int i = 0; i < 29; i++) send(1000, 10);
        en960k = 1'b1;
        din    = 16'(1000);
        @(negedge clk);
        en960k = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_audio_dat", longint'($signed(audio_dat)), 823);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_audio_dat", audio_dat, 0);
        chk("mid_rst_dout_valid", dout_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // DC -1000, one sample every clk; R=3 copy overruns at this rate
        d3_base = d3_cnt;
        base = out_log.size();
        for (int i = 0; i < 150; i++) send(-1000, 1);
        repeat (10) @(negedge clk);
        chk("dcn_count", out_log.size() - base, 5);
        chk("dcn_out3", logv(base + 3), -824);
        chk("dcn_out4", logv(base + 4), -824);
        chk("r30_overrun", overrun, 0);
        chk("r3_overrun", d3_ovr, 1);
        chk("r3_outputs_kept", d3_cnt - d3_base, 25);

        // full scale positive, integrators wrap many times
        pulse_reset();
        chk("r3_overrun_cleared", d3_ovr, 0);
        base = out_log.size();
        for (int i = 0; i < 600; i++) send(32767, 1);
        repeat (10) @(negedge clk);
        chk("fsp_count", out_log.size() - base, 20);
        chk("fsp_out10", logv(base + 10), 26999);
        chk("fsp_out19", logv(base + 19), 26999);

        // full scale negative
        pulse_reset();
        base = out_log.size();
        for (int i = 0; i < 600; i++) send(-32768, 1);
        repeat (10) @(negedge clk);
        chk("fsn_out19", logv(base + 19), -27000);

        // impulse response
        pulse_reset();
        base = out_log.size();
        send(32767, 1);
        for (int i = 0; i < 149; i++) send(0, 1);
        repeat (10) @(negedge clk);
        chk("imp_count", out_log.size() - base, 5);
        chk("imp_out0", logv(base + 0), 405);
        chk("imp_out1", logv(base + 1), 492);
        chk("imp_out2", logv(base + 2), 0);
        chk("imp_out3", logv(base + 3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
